// File: rtl/muldiv_defs.sv
// Shared op and state encodings for the iterative multiply/divide sequencer.
package muldiv_defs;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } md_state_e;

  function automatic logic op_is_div(input logic [1:0] op_v);
    return (op_v == MD_DIV) || (op_v == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op_v);
    return (op_v == MD_MULT) || (op_v == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-right add for multiply, shift-left restoring subtract for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH-1:0] upper;
  logic [WIDTH-1:0] lower;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;

  always_comb begin
    upper   = acc_i[2*WIDTH-1:WIDTH];
    lower   = acc_i[WIDTH-1:0];
    sum     = {1'b0, upper} + {1'b0, opnd_i};
    // partial remainder gains one bit per step, so it needs WIDTH+1 bits before the trial
    shifted = {upper, lower[WIDTH-1]};
    trial   = shifted - {1'b0, opnd_i};
    fits    = (shifted >= {1'b0, opnd_i});
    acc_o   = '0;
    if (is_div_i) begin
      if (fits) acc_o = {trial[WIDTH-1:0], lower[WIDTH-2:0], 1'b1};
      else      acc_o = {shifted[WIDTH-1:0], lower[WIDTH-2:0], 1'b0};
    end else begin
      if (lower[0]) acc_o = {sum, lower[WIDTH-1:1]};
      else          acc_o = {1'b0, upper, lower[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// MIPS HI/LO multiply/divide sequencer; divide support is built only when MULDIV_DIV_EN is defined,
// otherwise DIV/DIVU complete immediately with dz flagging an illegal op.
module muldiv_seq
  import muldiv_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  md_state_e          state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, hi_q, lo_q;
  logic               neg_q, busy_q, done_q, dz_q;
  logic               sgn, step_div;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] prod_fix;
`ifdef MULDIV_DIV_EN
  logic               is_div_q, rem_neg_q, dz_pend_q;
  logic [WIDTH-1:0]   a_raw_q, quo_fix, rem_fix;
  assign step_div = is_div_q;
`else
  assign step_div = 1'b0;
`endif

  always_comb begin
    sgn      = op_is_signed(op);
    a_abs    = (sgn && a[WIDTH-1]) ? -a : a;
    b_abs    = (sgn && b[WIDTH-1]) ? -b : b;
    prod_fix = neg_q ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
    quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif
  end

  // dividend sits in the low half for divide, multiplier in the low half for multiply
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (step_div),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q  <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_pend_q <= 1'b0;
      a_raw_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mt_hi) hi_q <= mt_data;
          if (mt_lo) lo_q <= mt_data;
          if (start) begin
`ifndef MULDIV_DIV_EN
            if (op_is_div(op)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              dz_q    <= 1'b1;
            end else
`endif
            begin
              state_q <= S_CALC;
              busy_q  <= 1'b1;
              cnt_q   <= CNT_LAST;
              acc_q   <= {{WIDTH{1'b0}}, a_abs};
              opnd_q  <= b_abs;
              neg_q   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
              is_div_q  <= op_is_div(op);
              rem_neg_q <= sgn & a[WIDTH-1];
              dz_pend_q <= op_is_div(op) && (b == '0);
              a_raw_q   <= a;
`endif
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          if (cnt_q == '0) state_q <= S_FIX;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        S_FIX: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
`ifdef MULDIV_DIV_EN
          if (is_div_q) begin
            if (dz_pend_q) begin
              hi_q <= a_raw_q;
              lo_q <= '1;
              dz_q <= 1'b1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
`else
          {hi_q, lo_q} <= prod_fix;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table plus hand sequences for mt writes, ignored starts and reset.
module tb_muldiv_seq;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, mt_hi, mt_lo;
  logic [1:0]  op;
  logic [31:0] a, b, mt_data;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, ehi, elo;
    logic        edz;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output int bcnt, output logic dzv, output logic bsy);
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
    dzv = dz;
    bsy = busy;
  endtask

  vec_t vt[14];

  initial begin
    int lat, bcnt, k, nd;
    logic dzv, bsy, isd, ill;
    logic [31:0] m_hi, m_lo, ehi, elo;

    vt[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vt[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vt[2]  = '{2'b00, 32'h00000007, 32'h00000006, 32'h00000000, 32'h0000002A, 1'b0};
    vt[3]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vt[4]  = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vt[5]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vt[6]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vt[7]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vt[8]  = '{2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
    vt[9]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vt[10] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vt[11] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vt[12] = '{2'b11, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0};
    vt[13] = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};

    reset = 1'b1; start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
    op = 2'b00; a = '0; b = '0; mt_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dz",   {31'd0, dz},   32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;

    for (int i = 0; i < 14; i++) begin
      isd = vt[i].op[1];
      ill = isd && !DIV_EN;
      ehi = ill ? m_hi : vt[i].ehi;
      elo = ill ? m_lo : vt[i].elo;
      run_op(vt[i].op, vt[i].a, vt[i].b, lat, bcnt, dzv, bsy);
      chk($sformatf("v%0d_lat", i), lat, ill ? 32'd0 : 32'd33);
      chk($sformatf("v%0d_busy_cycles", i), bcnt, ill ? 32'd0 : 32'd33);
      chk($sformatf("v%0d_busy_at_done", i), {31'd0, bsy}, 32'd0);
      chk($sformatf("v%0d_dz", i), {31'd0, dzv}, {31'd0, ill ? 1'b1 : vt[i].edz});
      chk($sformatf("v%0d_hi", i), hi, ehi);
      chk($sformatf("v%0d_lo", i), lo, elo);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
      m_hi = ehi; m_lo = elo;
    end

    // MTHI+MTLO together, then MTLO alone
    @(negedge clk);
    mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'h0F0F0F0F;
    @(posedge clk); #1;
    mt_hi = 1'b0; mt_lo = 1'b0;
    chk("mt_both_hi", hi, 32'h0F0F0F0F);
    chk("mt_both_lo", lo, 32'h0F0F0F0F);
    @(negedge clk);
    mt_lo = 1'b1; mt_data = 32'hA5A5A5A5;
    @(posedge clk); #1;
    mt_lo = 1'b0;
    chk("mtlo_lo", lo, 32'hA5A5A5A5);
    chk("mtlo_hi", hi, 32'h0F0F0F0F);

    // mt strobes and a second start during CALC are dropped
    @(negedge clk);
    op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'hDEADBEEF;
    start = 1'b1; op = 2'b01; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    mt_hi = 1'b0; mt_lo = 1'b0; start = 1'b0;
    chk("calc_mt_lo", lo, 32'hA5A5A5A5);
    chk("calc_mt_hi", hi, 32'h0F0F0F0F);
    chk("calc_busy", {31'd0, busy}, 32'd1);
    k = 6;
    while (!done && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("calc_lat", done ? k : -1, 32'd33);
    chk("calc_res_hi", hi, 32'd0);
    chk("calc_res_lo", lo, 32'd12);
    nd = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("second_start_ignored", nd, 32'd0);

    // mt write alongside start lands first, result overwrites it at FIX
    @(negedge clk);
    mt_hi = 1'b1; mt_data = 32'h11111111;
    start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
    @(posedge clk); #1;
    mt_hi = 1'b0; start = 1'b0;
    chk("mtstart_hi", hi, 32'h11111111);
    k = 0;
    while (!done && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("mtstart_lat", done ? k : -1, 32'd33);
    chk("mtstart_res_hi", hi, 32'd0);
    chk("mtstart_res_lo", lo, 32'd6);

    // reset in the middle of CALC
    @(negedge clk);
    op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("midrst_no_done", nd, 32'd0);
    run_op(2'b01, 32'd6, 32'd7, lat, bcnt, dzv, bsy);
    chk("postrst_lat", lat, 32'd33);
    chk("postrst_hi", hi, 32'd0);
    chk("postrst_lo", lo, 32'd42);
    chk("postrst_dz", {31'd0, dzv}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
